alu_ex_stage: RTL and testbench

- Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder.
- Applies the operation to two operands and registers the result, zero flag and destination tag into the EX/MEM boundary.
- Uses a valid/ready handshake with a one-entry skid buffer, so downstream back-pressure never drops or corrupts an accepted operation.
- Supports a pipeline flush for branch mispredict.

---
 rtl/alu_ex_stage.sv | 132 +++++++++++++
 tb/tb_alu_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// alu_ex_stage
// Execute-stage ALU sitting between the ALU control decoder and the EX/MEM
// boundary. Computes AND/OR/ADD/SUB on two operands and registers the result,
// a zero flag, an illegal-op flag and the destination tag. A valid/ready
// handshake with a one-entry skid buffer lets downstream stall without
// dropping or reordering any accepted operation. A flush input discards all
// held and incoming work (branch mispredict).
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    upstream presents an operation
//   in_ready    stage can accept this cycle (registered, = ~skid_valid)
//   operation   4-bit ALU op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   a, b        operands (WIDTH bits)
//   rd_in       destination tag, passed through (RD_W bits)
//   flush       discard all held and incoming work
//   out_valid   result register holds valid data
//   out_ready   downstream accepts this cycle
//   result      registered ALU result
//   zero        registered (result == 0)
//   illegal_op  registered flag: op code was not one of the four legal codes
//   rd_out      registered destination tag

module alu_ex_stage #(
  parameter int WIDTH = 64,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RD_W-1:0]  rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op,
  output logic [RD_W-1:0]  rd_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // Skid buffer: holds one accepted op while the main register is stalled.
  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic             skid_zero;
  logic             skid_illegal;
  logic [RD_W-1:0]  skid_rd;

  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             alu_zero;
  logic             accept;
  logic             main_free;

  // in_ready depends only on registered state, so there is no combinational
  // path from out_ready back to upstream.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid && in_ready;
  // Main register can take new data when it is empty or draining this cycle.
  assign main_free = !out_valid || out_ready;

  // Combinational ALU on the presented operands. Illegal codes yield 0,
  // which makes zero come out as 1 through the normal zero computation.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (operation)
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_ADD:  alu_result = a + b;
      OP_SUB:  alu_result = a - b;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      illegal_op   <= 1'b0;
      rd_out       <= '0;
      skid_valid   <= 1'b0;
      skid_result  <= '0;
      skid_zero    <= 1'b0;
      skid_illegal <= 1'b0;
      skid_rd      <= '0;
    end else if (flush) begin
      // Payloads keep stale values; the cleared valid bits mask them.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid entry is older than anything upstream, so it goes first.
        // in_ready was 0 this cycle, so no accept can collide with it.
        out_valid  <= 1'b1;
        result     <= skid_result;
        zero       <= skid_zero;
        illegal_op <= skid_illegal;
        rd_out     <= skid_rd;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        result     <= alu_result;
        zero       <= alu_zero;
        illegal_op <= alu_illegal;
        rd_out     <= rd_in;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new op in the skid buffer.
      skid_valid   <= 1'b1;
      skid_result  <= alu_result;
      skid_zero    <= alu_zero;
      skid_illegal <= alu_illegal;
      skid_rd      <= rd_in;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage
// Directed self-checking bench for alu_ex_stage: reset values, single-op
// latency, SUB wrap/zero, back-pressure through the skid buffer, illegal
// op codes, flush and reset in the middle of work.

module tb_alu_ex_stage;

  localparam int WIDTH = 64;
  localparam int RD_W  = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [RD_W-1:0]  rd_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal_op;
  logic [RD_W-1:0]  rd_out;

  int checks;
  int errors;

  alu_ex_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal_op(illegal_op), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain anything in flight with inputs idle.
  task automatic idle(input int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    operation = 4'b0000; a = '0; b = '0; rd_in = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got %b want 0", zero); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b want 0", illegal_op); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd got %0d want 0", rd_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    in_valid = 1'b1; operation = 4'b0010; a = 64'd5; b = 64'd7; rd_in = 5'd3;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %b want 1", out_valid); end
    checks++; if (result !== 64'd12) begin errors++; $display("[TB] FAIL add_result got %h want c", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %b want 0", zero); end
    checks++; if (rd_out !== 5'd3) begin errors++; $display("[TB] FAIL add_rd got %0d want 3", rd_out); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL add_illegal got %b want 0", illegal_op); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drained got %b want 0", out_valid); end
    idle(2);
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    in_valid = 1'b1; operation = 4'b0110; a = 64'd0; b = 64'd1; rd_in = 5'd7;
    step();
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL sub_wrap_result got %h want ffffffffffffffff", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL sub_wrap_zero got %b want 0", zero); end
    a = 64'd9; b = 64'd9; rd_in = 5'd8;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sub_eq_valid got %b want 1", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL sub_eq_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_eq_zero got %b want 1", zero); end
    checks++; if (rd_out !== 5'd8) begin errors++; $display("[TB] FAIL sub_eq_rd got %0d want 8", rd_out); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] seen[$];
    logic [RD_W-1:0]  seen_rd[$];
    logic             acc;
    out_ready = 1'b0;
    in_valid = 1'b1; operation = 4'b0000; a = 64'hF0; b = 64'h3C; rd_in = 5'd1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1 got %b want 1", in_ready); end
    checks++; if (result !== 64'h30) begin errors++; $display("[TB] FAIL bp_first_result got %h want 30", result); end
    operation = 4'b0001; a = 64'hF0; b = 64'h0F; rd_in = 5'd2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2 got %b want 0", in_ready); end
    operation = 4'b0010; a = 64'd1; b = 64'd1; rd_in = 5'd3;
    step();
    checks++; if (result !== 64'h30 || rd_out !== 5'd1) begin errors++; $display("[TB] FAIL bp_hold got %h/%0d want 30/1", result, rd_out); end
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall got ready %b valid %b want 0 1", in_ready, out_valid); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin seen.push_back(result); seen_rd.push_back(rd_out); end
      step();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (seen.size() != 3) begin errors++; $display("[TB] FAIL bp_count got %0d want 3", seen.size()); end
    if (seen.size() > 0) begin checks++; if (seen[0] !== 64'h30 || seen_rd[0] !== 5'd1) begin errors++; $display("[TB] FAIL bp_out0 got %h/%0d want 30/1", seen[0], seen_rd[0]); end end
    if (seen.size() > 1) begin checks++; if (seen[1] !== 64'hFF || seen_rd[1] !== 5'd2) begin errors++; $display("[TB] FAIL bp_out1 got %h/%0d want ff/2", seen[1], seen_rd[1]); end end
    if (seen.size() > 2) begin checks++; if (seen[2] !== 64'd2 || seen_rd[2] !== 5'd3) begin errors++; $display("[TB] FAIL bp_out2 got %h/%0d want 2/3", seen[2], seen_rd[2]); end end
    idle(2);
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; operation = 4'b0101; a = 64'd3; b = 64'd4; rd_in = 5'd9;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid got %b want 1", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL illegal_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL illegal_zero got %b want 1", zero); end
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag got %b want 1", illegal_op); end
    idle(2);
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] seen[$];
    logic             acc;
    // Flush while accepting into an empty stage: the op is discarded.
    out_ready = 1'b1;
    in_valid = 1'b1; flush = 1'b1; operation = 4'b0000; a = 64'hFF; b = 64'hFF; rd_in = 5'd5;
    step();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_accept_valid got %b want 0", out_valid); end
    // Fill main and skid, then flush with in_valid asserted.
    out_ready = 1'b0;
    in_valid = 1'b1; operation = 4'b0000; a = 64'hF0; b = 64'h3C; rd_in = 5'd1;
    step();
    operation = 4'b0001; rd_in = 5'd2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_fill got ready %b want 0", in_ready); end
    operation = 4'b0010; a = 64'd7; b = 64'd7; rd_in = 5'd6; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; operation = 4'b0010; a = 64'd2; b = 64'd2; rd_in = 5'd4;
    for (int cyc = 0; cyc < 8; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) seen.push_back(result);
      step();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (seen.size() != 1) begin errors++; $display("[TB] FAIL flush_count got %0d want 1", seen.size()); end
    if (seen.size() > 0) begin checks++; if (seen[0] !== 64'd4) begin errors++; $display("[TB] FAIL flush_result got %h want 4", seen[0]); end end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int outs;
    out_ready = 1'b0;
    in_valid = 1'b1; operation = 4'b0010; a = 64'd5; b = 64'd7; rd_in = 5'd3;
    step();
    operation = 4'b0001; a = 64'h1; b = 64'h2; rd_in = 5'd4;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fill got valid %b ready %b want 1 0", out_valid, in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b want 0", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL rmid_result got %h want 0", result); end
    checks++; if (zero !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flags got %b %b want 0 0", zero, illegal_op); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("[TB] FAIL rmid_rd got %0d want 0", rd_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    outs = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (out_valid) outs++;
      step();
    end
    checks++; if (outs != 0) begin errors++; $display("[TB] FAIL rmid_leftover got %0d want 0", outs); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
